// File: rtl/bcd_counter_updown.sv
// bcd_counter_updown
//   Cascadable multi-digit BCD up/down counter with synchronous parallel
//   load, a combinational terminal-count output for chaining stages, and
//   registered wrap / rejected-load pulses. Every digit field of the count
//   always holds a legal BCD code 0-9.
//
// Parameters
//   DIGITS        number of BCD digits, legal range 1-4
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous active-high reset (count, wrap and load_err to 0)
//   en_i          count enable (carry/borrow input when cascaded)
//   up_i          direction: 1 = count up, 0 = count down
//   load_i        synchronous parallel load request (overrides en_i)
//   load_val_i    load value, digit k in [4k+3:4k]
//   bcd_o         registered count, digit k in [4k+3:4k]
//   tc_o          combinational terminal count, feeds en_i of the next stage
//   wrap_o        one-cycle pulse after the counter wrapped
//   load_err_o    one-cycle pulse after a load containing a digit above 9
module bcd_counter_updown #(
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  tc_o,
  output logic                  wrap_o,
  output logic                  load_err_o
);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;

  logic [4*DIGITS-1:0] cnt_d;
  logic                all9, all0, load_ok;

  // Per-digit increment; codes 10-15 cannot occur but are steered to 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    if (d >= 4'd9) return 4'd0;
    else           return d + 4'd1;
  endfunction

  // Per-digit decrement; 0 and the illegal codes 10-15 both go to 9.
  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    if ((d == 4'd0) || (d > 4'd9)) return 4'd9;
    else                           return d - 4'd1;
  endfunction

  // Ripple carry/borrow through the digits, starting with digit 0 always
  // stepping. A digit passes the carry on only when it rolls over from its
  // terminal value (9 going up, 0 going down).
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    logic [3:0] ld;
    cnt_d   = bcd_q;
    carry   = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    load_ok = 1'b1;
    dig     = 4'd0;
    ld      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = bcd_q[4*k +: 4];
      ld  = load_val_i[4*k +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (ld > 4'd9)   load_ok = 1'b0;
      if (carry) begin
        cnt_d[4*k +: 4] = up_i ? digit_inc(dig) : digit_dec(dig);
        carry = up_i ? (dig == 4'd9) : (dig == 4'd0);
      end
    end
  end

  // Terminal count ignores reset on purpose: it only describes what the
  // next enabled, non-load edge would do.
  assign tc_o = en_i & ~load_i & (up_i ? all9 : all0);

  always_comb begin
    bcd_d = bcd_q;
    if (load_i) begin
      if (load_ok) bcd_d = load_val_i;
    end else if (en_i) begin
      bcd_d = cnt_d;
    end
  end

  assign wrap_d     = tc_o;
  assign load_err_d = load_i & ~load_ok;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bcd_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd_o      = bcd_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_counter_updown.sv
// Testbench for bcd_counter_updown: a 2-digit instance plus a cascade of two
// 1-digit instances (lower tc into upper en), all sharing the same stimulus.
// Expected values come from a decimal reference model and are queued at
// drive time, then popped and compared after the clock edge.
module tb_bcd_counter_updown;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] bcd;
  logic       tc, wrap, load_err;

  logic [3:0] lo_bcd, hi_bcd;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

  always #5 clk = ~clk;

  bcd_counter_updown #(.DIGITS(2)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(load_val), .bcd_o(bcd), .tc_o(tc), .wrap_o(wrap),
    .load_err_o(load_err)
  );

  bcd_counter_updown #(.DIGITS(1)) u_lo (
    .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(load_val[3:0]), .bcd_o(lo_bcd), .tc_o(lo_tc),
    .wrap_o(lo_wrap), .load_err_o(lo_err)
  );

  bcd_counter_updown #(.DIGITS(1)) u_hi (
    .clk_i(clk), .reset_i(reset), .en_i(lo_tc), .up_i(up), .load_i(load),
    .load_val_i(load_val[7:4]), .bcd_o(hi_bcd), .tc_o(hi_tc),
    .wrap_o(hi_wrap), .load_err_o(hi_err)
  );

  typedef struct {
    logic [7:0] bcd;
    logic       wrap;
    logic       err;
    logic       pair;
  } exp_t;

  exp_t sbq[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_val = 0;
  bit   m_known = 1'b0;
  bit   pair_on = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock of stimulus: drive, check tc in-cycle, queue expectation,
  // clock, then pop and check the registered outputs.
  task automatic step(input logic r, input logic e, input logic u,
                      input logic l, input logic [7:0] lv);
    exp_t x;
    logic tce;
    logic ok;
    reset = r; en = e; up = u; load = l; load_val = lv;
    #1;
    tce = 1'b0;
    if (m_known) begin
      tce = e & ~l & (u ? (m_val == 99) : (m_val == 0));
      chk("tc", {7'b0, tc}, {7'b0, tce});
      if (pair_on)
        chk("lo_tc", {7'b0, lo_tc},
            {7'b0, e & ~l & (u ? (m_val % 10 == 9) : (m_val % 10 == 0))});
    end
    ok = (lv[3:0] <= 4'd9) && (lv[7:4] <= 4'd9);
    if (r) begin
      m_val  = 0;
      x.wrap = 1'b0;
      x.err  = 1'b0;
    end else begin
      x.wrap = tce;
      x.err  = l & ~ok;
      if (l) begin
        if (ok) m_val = int'(lv[7:4]) * 10 + int'(lv[3:0]);
      end else if (e) begin
        m_val = u ? (m_val + 1) % 100 : (m_val + 99) % 100;
      end
    end
    m_known = m_known | r | (l & ok);
    x.bcd  = to_bcd(m_val);
    x.pair = pair_on;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      x = sbq.pop_front();
      chk("bcd", bcd, x.bcd);
      chk("wrap", {7'b0, wrap}, {7'b0, x.wrap});
      chk("load_err", {7'b0, load_err}, {7'b0, x.err});
      if (x.pair) chk("cascade_bcd", {hi_bcd, lo_bcd}, x.bcd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  logic       r_r, r_e, r_u, r_l;
  logic [7:0] r_lv;

  initial begin
    @(posedge clk);
    #1;
    // Reset, then 12 up counts: 01 .. 12
    step(1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 8'h00);
    // Up-wrap from 98
    step(0, 0, 1, 1, 8'h98);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00);
    // Down-count and down-wrap from 01
    step(0, 0, 0, 1, 8'h01);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    // Invalid load rejected, then a valid load
    step(0, 0, 1, 1, 8'h37);
    step(0, 0, 1, 1, 8'h3C);
    step(0, 0, 1, 1, 8'hA2);
    step(0, 0, 1, 1, 8'h42);
    // Hold with en=0
    step(0, 0, 1, 0, 8'h00);
    // Load beats counting at a terminal value
    step(0, 0, 1, 1, 8'h99);
    step(0, 1, 1, 1, 8'h05);
    // Reset beats load and en
    step(0, 0, 1, 1, 8'h99);
    step(1, 1, 1, 1, 8'h55);
    // Reset at terminal value: tc still high, wrap suppressed
    step(0, 0, 1, 1, 8'h99);
    step(1, 1, 1, 0, 8'h00);
    // Down count from reset value wraps to 99, then direction change
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    // Cascade: load 09, count up to 10, then randomized traffic
    pair_on = 1'b1;
    step(0, 0, 1, 1, 8'h09);
    step(0, 1, 1, 0, 8'h00);
    for (int i = 0; i < 120; i++) begin
      r_r  = ($urandom_range(0, 39) == 0);
      r_l  = ($urandom_range(0, 11) == 0);
      r_e  = ($urandom_range(0, 3) != 0);
      r_u  = (i < 60) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      r_lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step(r_r, r_e, r_u, r_l, r_lv);
    end
    step(0, 0, 1, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
